vc_circular_buffer: RTL and testbench

Multi-virtual-channel input buffer for a NoC router port: one circular FIFO per VC behind a single write port and a single read port, each addressed by a VC index. Sits between the link receiver and the VC allocator/crossbar, and supplies the per-VC on/off flow-control signals returned upstream. Successor to the single-queue buffer, with these additions:
- arbitrary (non-power-of-two) depth;
- per-VC hysteresis thresholds;
- exposed occupancy counts;
- defined overflow and underflow reporting.

---
 rtl/vc_circular_buffer_pkg.sv | 28 ++
 rtl/vc_circular_buffer_if.sv | 41 ++++
 rtl/vc_circular_buffer_vc_fifo_slice.sv | 92 +++++++++
 rtl/vc_circular_buffer.sv | 87 ++++++++
 tb/tb_vc_circular_buffer.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vc_circular_buffer_pkg.sv
// params_noc: shared NoC types and width helpers for the VC input buffer.
//   flit_Data_noVC      - flit payload without VC field
//   VC_NUM_DEFAULT      - default number of virtual channels
//   BUFFER_SIZE_DEFAULT - default flits per VC
//   VC_W / CNT_W        - VC index and occupancy widths for the defaults
//   vc_width/cnt_width  - the same derivations for arbitrary parameters
package params_noc;

    localparam int FLIT_W = 32;
    typedef logic [FLIT_W-1:0] flit_Data_noVC;

    localparam int VC_NUM_DEFAULT      = 2;
    localparam int BUFFER_SIZE_DEFAULT = 8;

    // A single VC still needs a 1-bit index so ports never collapse to zero width.
    function automatic int vc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Occupancy runs 0..n inclusive, hence n+1 states.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int VC_W  = vc_width(VC_NUM_DEFAULT);
    localparam int CNT_W = cnt_width(BUFFER_SIZE_DEFAULT);

endpackage

// File: rtl/vc_circular_buffer_if.sv
// Bus between the link receiver / VC allocator (master) and the VC buffer (slave).
//   input_Data, write_i, wr_vc_i   - write port
//   read_i, rd_vc_i, output_Data   - read port (fall-through head of rd_vc_i)
//   buf_empty, buf_full, buf_On_Off, num_Flits - per-VC status
//   overflow_o, underflow_o        - one-cycle rejected-request pulses
interface vc_circular_buffer_if
    import params_noc::*;
#(
    parameter int VC_NUM      = VC_NUM_DEFAULT,
    parameter int BUFFER_SIZE = BUFFER_SIZE_DEFAULT
);

    localparam int VC_IDX_W = vc_width(VC_NUM);
    localparam int OCC_W    = cnt_width(BUFFER_SIZE);

    flit_Data_noVC                   input_Data;
    logic                            write_i;
    logic [VC_IDX_W-1:0]             wr_vc_i;
    logic                            read_i;
    logic [VC_IDX_W-1:0]             rd_vc_i;
    flit_Data_noVC                   output_Data;
    logic [VC_NUM-1:0]               buf_empty;
    logic [VC_NUM-1:0]               buf_full;
    logic [VC_NUM-1:0]               buf_On_Off;
    logic [VC_NUM-1:0][OCC_W-1:0]    num_Flits;
    logic                            overflow_o;
    logic                            underflow_o;

    modport master (
        output input_Data, write_i, wr_vc_i, read_i, rd_vc_i,
        input  output_Data, buf_empty, buf_full, buf_On_Off, num_Flits,
               overflow_o, underflow_o
    );

    modport slave (
        input  input_Data, write_i, wr_vc_i, read_i, rd_vc_i,
        output output_Data, buf_empty, buf_full, buf_On_Off, num_Flits,
               overflow_o, underflow_o
    );

endinterface

// File: rtl/vc_circular_buffer_vc_fifo_slice.sv
// vc_fifo_slice: one VC's circular flit store with occupancy count, registered
// empty/full flags and on/off hysteresis. Accept decisions are made by the parent.
//   clk, rst_n      - clock, async active-low reset
//   wr_en, wr_data  - accepted write and its flit
//   rd_en           - accepted read (pop)
//   rd_data         - current head slot (stale when empty)
//   empty, full     - registered occupancy flags
//   on_off          - registered upstream permit
//   count           - registered occupancy 0..BUFFER_SIZE
module vc_fifo_slice
    import params_noc::*;
#(
    parameter int BUFFER_SIZE   = BUFFER_SIZE_DEFAULT,
    parameter int OFF_THRESHOLD = BUFFER_SIZE - 1,
    parameter int ON_THRESHOLD  = 1,
    localparam int OCC_W        = cnt_width(BUFFER_SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  flit_Data_noVC    wr_data,
    input  logic             rd_en,
    output flit_Data_noVC    rd_data,
    output logic             empty,
    output logic             full,
    output logic             on_off,
    output logic [OCC_W-1:0] count
);

    localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUFFER_SIZE - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(BUFFER_SIZE);
    localparam logic [OCC_W-1:0] OFF_LVL  = OCC_W'(OFF_THRESHOLD);
    localparam logic [OCC_W-1:0] ON_LVL   = OCC_W'(ON_THRESHOLD);

    flit_Data_noVC    mem_q [BUFFER_SIZE];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             empty_q, full_q;
    logic             on_off_q, on_off_d;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + OCC_W'(wr_en) - OCC_W'(rd_en);
        // Hysteresis acts on the post-update count; between thresholds hold.
        on_off_d = on_off_q;
        if (count_d >= OFF_LVL) begin
            on_off_d = 1'b0;
        end else if (count_d <= ON_LVL) begin
            on_off_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            on_off_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == OCC_FULL);
            on_off_q <= on_off_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = empty_q;
    assign full    = full_q;
    assign on_off  = on_off_q;
    assign count   = count_q;

endmodule

// File: rtl/vc_circular_buffer.sv
// vc_circular_buffer: multi-VC router input buffer. One vc_fifo_slice per VC
// behind a shared write port and a shared read port, each addressed by VC index.
//   clk, rst_n - clock, async active-low reset
//   bus        - slave side of vc_circular_buffer_if (data, requests, status, pulses)
module vc_circular_buffer
    import params_noc::*;
#(
    parameter int VC_NUM        = VC_NUM_DEFAULT,
    parameter int BUFFER_SIZE   = BUFFER_SIZE_DEFAULT,
    parameter int OFF_THRESHOLD = BUFFER_SIZE - 1,
    parameter int ON_THRESHOLD  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vc_circular_buffer_if.slave   bus
);

    localparam int VC_IDX_W = vc_width(VC_NUM);
    localparam int OCC_W    = cnt_width(BUFFER_SIZE);

    logic [VC_NUM-1:0]            wr_sel, rd_sel, wr_en, rd_en;
    logic [VC_NUM-1:0]            empty_v, full_v, on_off_v;
    logic [VC_NUM-1:0][OCC_W-1:0] count_v;
    flit_Data_noVC                rd_data_v [VC_NUM];
    logic                         overflow_q, underflow_q;

    // An index >= VC_NUM matches no slice, so it is rejected naturally.
    always_comb begin
        wr_sel = '0;
        rd_sel = '0;
        wr_en  = '0;
        rd_en  = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            wr_sel[v] = bus.write_i && (bus.wr_vc_i == VC_IDX_W'(v));
            rd_sel[v] = bus.read_i && (bus.rd_vc_i == VC_IDX_W'(v));
            rd_en[v]  = rd_sel[v] && !empty_v[v];
            // A full VC still takes a write when it is popped in the same cycle.
            wr_en[v]  = wr_sel[v] && (!full_v[v] || rd_sel[v]);
        end
    end

    always_comb begin
        bus.output_Data = rd_data_v[0];
        for (int v = 0; v < VC_NUM; v++) begin
            if (bus.rd_vc_i == VC_IDX_W'(v)) begin
                bus.output_Data = rd_data_v[v];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= bus.write_i && !(|wr_en);
            underflow_q <= bus.read_i && !(|rd_en);
        end
    end

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        vc_fifo_slice #(
            .BUFFER_SIZE   (BUFFER_SIZE),
            .OFF_THRESHOLD (OFF_THRESHOLD),
            .ON_THRESHOLD  (ON_THRESHOLD)
        ) u_slice (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en[v]),
            .wr_data (bus.input_Data),
            .rd_en   (rd_en[v]),
            .rd_data (rd_data_v[v]),
            .empty   (empty_v[v]),
            .full    (full_v[v]),
            .on_off  (on_off_v[v]),
            .count   (count_v[v])
        );
    end

    assign bus.buf_empty   = empty_v;
    assign bus.buf_full    = full_v;
    assign bus.buf_On_Off  = on_off_v;
    assign bus.num_Flits   = count_v;
    assign bus.overflow_o  = overflow_q;
    assign bus.underflow_o = underflow_q;

endmodule

// File: tb/tb_vc_circular_buffer.sv
// Bench for vc_circular_buffer: an 8-deep 2-VC instance and a 5-deep 3-VC instance
// share clock and reset. Expected flits are queued per VC on accepted writes and
// popped/compared against output_Data on reads.
module tb_vc_circular_buffer;
    import params_noc::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    flit_Data_noVC q8_1 [$];
    flit_Data_noVC q5_0 [$];
    flit_Data_noVC q5_1 [$];
    flit_Data_noVC q5_2 [$];
    flit_Data_noVC exp_d;

    always #5 clk = ~clk;

    vc_circular_buffer_if #(.VC_NUM(2), .BUFFER_SIZE(8)) if8 ();
    vc_circular_buffer_if #(.VC_NUM(3), .BUFFER_SIZE(5)) if5 ();

    vc_circular_buffer #(
        .VC_NUM(2), .BUFFER_SIZE(8), .OFF_THRESHOLD(7), .ON_THRESHOLD(1)
    ) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8.slave)
    );

    vc_circular_buffer #(
        .VC_NUM(3), .BUFFER_SIZE(5), .OFF_THRESHOLD(4), .ON_THRESHOLD(1)
    ) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if5.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic w, input logic wvc, input flit_Data_noVC d,
                          input logic r, input logic rvc);
        if8.write_i    = w;
        if8.wr_vc_i    = wvc;
        if8.input_Data = d;
        if8.read_i     = r;
        if8.rd_vc_i    = rvc;
    endtask

    task automatic drive5(input logic w, input logic [1:0] wvc, input flit_Data_noVC d,
                          input logic r, input logic [1:0] rvc);
        if5.write_i    = w;
        if5.wr_vc_i    = wvc;
        if5.input_Data = d;
        if5.read_i     = r;
        if5.rd_vc_i    = rvc;
    endtask

    task automatic test_reset();
        drive8(1'b0, 1'b0, '0, 1'b0, 1'b0);
        drive5(1'b0, 2'd0, '0, 1'b0, 2'd0);
        rst_n = 1'b0;
        #7;
        n_cmp++;
        if (if8.buf_empty !== 2'b11) begin
            n_bad++; $display("FAIL reset_empty8: got %b want 11", if8.buf_empty);
        end
        n_cmp++;
        if (if8.buf_full !== 2'b00) begin
            n_bad++; $display("FAIL reset_full8: got %b want 00", if8.buf_full);
        end
        n_cmp++;
        if (if8.buf_On_Off !== 2'b11) begin
            n_bad++; $display("FAIL reset_onoff8: got %b want 11", if8.buf_On_Off);
        end
        n_cmp++;
        if (if8.num_Flits !== 8'h00) begin
            n_bad++; $display("FAIL reset_count8: got %h want 00", if8.num_Flits);
        end
        n_cmp++;
        if ({if8.overflow_o, if8.underflow_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_pulses8: got %b%b want 00", if8.overflow_o, if8.underflow_o);
        end
        n_cmp++;
        if (if5.buf_empty !== 3'b111 || if5.buf_On_Off !== 3'b111) begin
            n_bad++;
            $display("FAIL reset_flags5: got empty %b onoff %b want 111 111",
                     if5.buf_empty, if5.buf_On_Off);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill_vc1();
        for (int i = 0; i < 8; i++) begin
            exp_d = 32'h100 + i;
            drive8(1'b1, 1'b1, exp_d, 1'b0, 1'b1);
            q8_1.push_back(exp_d);
            tick();
            n_cmp++;
            if (if8.num_Flits[1] !== 4'(i + 1)) begin
                n_bad++;
                $display("FAIL fill_count[%0d]: got %0d want %0d", i, if8.num_Flits[1], i + 1);
            end
            n_cmp++;
            if (if8.buf_On_Off[1] !== ((i + 1 >= 7) ? 1'b0 : 1'b1)) begin
                n_bad++;
                $display("FAIL fill_onoff[%0d]: got %b want %b", i, if8.buf_On_Off[1],
                         (i + 1 >= 7) ? 1'b0 : 1'b1);
            end
        end
        drive8(1'b0, 1'b0, '0, 1'b0, 1'b1);
        n_cmp++;
        if (if8.buf_full !== 2'b10) begin
            n_bad++; $display("FAIL fill_full: got %b want 10", if8.buf_full);
        end
        n_cmp++;
        if (if8.buf_empty[0] !== 1'b1 || if8.num_Flits[0] !== 4'd0) begin
            n_bad++;
            $display("FAIL fill_vc0_untouched: got empty %b count %0d want 1 0",
                     if8.buf_empty[0], if8.num_Flits[0]);
        end
    endtask

    task automatic test_overflow();
        drive8(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        tick();
        drive8(1'b0, 1'b0, '0, 1'b0, 1'b1);
        n_cmp++;
        if (if8.overflow_o !== 1'b1 || if8.num_Flits[1] !== 4'd8) begin
            n_bad++;
            $display("FAIL ovf_pulse: got ovf %b count %0d want 1 8",
                     if8.overflow_o, if8.num_Flits[1]);
        end
        tick();
        n_cmp++;
        if (if8.overflow_o !== 1'b0) begin
            n_bad++; $display("FAIL ovf_one_cycle: got %b want 0", if8.overflow_o);
        end
        n_cmp++;
        if (if8.output_Data !== q8_1[0]) begin
            n_bad++; $display("FAIL ovf_head: got %h want %h", if8.output_Data, q8_1[0]);
        end
    endtask

    task automatic test_full_rw();
        drive8(1'b1, 1'b1, 32'h200, 1'b1, 1'b1);
        #1;
        exp_d = q8_1.pop_front();
        n_cmp++;
        if (if8.output_Data !== exp_d) begin
            n_bad++; $display("FAIL full_rw_pop: got %h want %h", if8.output_Data, exp_d);
        end
        q8_1.push_back(32'h200);
        tick();
        drive8(1'b0, 1'b0, '0, 1'b0, 1'b1);
        n_cmp++;
        if (if8.num_Flits[1] !== 4'd8 || if8.buf_full[1] !== 1'b1 ||
            if8.overflow_o !== 1'b0 || if8.underflow_o !== 1'b0) begin
            n_bad++;
            $display("FAIL full_rw_state: got count %0d full %b ovf %b unf %b want 8 1 0 0",
                     if8.num_Flits[1], if8.buf_full[1], if8.overflow_o, if8.underflow_o);
        end
    endtask

    task automatic test_drain_reset();
        for (int k = 0; k < 8; k++) begin
            drive8(1'b0, 1'b0, '0, 1'b1, 1'b1);
            #1;
            exp_d = q8_1.pop_front();
            n_cmp++;
            if (if8.output_Data !== exp_d) begin
                n_bad++;
                $display("FAIL drain_data[%0d]: got %h want %h", k, if8.output_Data, exp_d);
            end
            tick();
            // Falling from full: permit stays off until the count reaches ON_THRESHOLD.
            n_cmp++;
            if (if8.buf_On_Off[1] !== ((7 - k) <= 1)) begin
                n_bad++;
                $display("FAIL drain_onoff[%0d]: got %b want %b", k, if8.buf_On_Off[1],
                         ((7 - k) <= 1));
            end
        end
        drive8(1'b0, 1'b0, '0, 1'b0, 1'b1);
        n_cmp++;
        if (if8.buf_empty[1] !== 1'b1) begin
            n_bad++; $display("FAIL drain_empty: got %b want 1", if8.buf_empty[1]);
        end
        for (int i = 0; i < 3; i++) begin
            drive8(1'b1, 1'b1, 32'h300 + i, 1'b0, 1'b1);
            q8_1.push_back(32'h300 + i);
            tick();
        end
        drive8(1'b0, 1'b0, '0, 1'b1, 1'b1);
        #1;
        exp_d = q8_1.pop_front();
        n_cmp++;
        if (if8.output_Data !== exp_d) begin
            n_bad++; $display("FAIL middrain_data: got %h want %h", if8.output_Data, exp_d);
        end
        tick();
        drive8(1'b0, 1'b0, '0, 1'b0, 1'b1);
        n_cmp++;
        if (if8.num_Flits[1] !== 4'd2) begin
            n_bad++; $display("FAIL middrain_count: got %0d want 2", if8.num_Flits[1]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (if8.num_Flits !== 8'h00 || if8.buf_empty !== 2'b11 ||
            if8.buf_On_Off !== 2'b11 || if8.buf_full !== 2'b00) begin
            n_bad++;
            $display("FAIL async_reset: got count %h empty %b onoff %b full %b want 00 11 11 00",
                     if8.num_Flits, if8.buf_empty, if8.buf_On_Off, if8.buf_full);
        end
        q8_1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        int n;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            drive5(1'b1, 2'd0, 32'h500 + n, 1'b0, 2'd0);
            q5_0.push_back(32'h500 + n);
            n++;
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            if (i < 9) begin
                drive5(1'b1, 2'd0, 32'h500 + n, 1'b1, 2'd0);
            end else begin
                drive5(1'b0, 2'd0, '0, 1'b1, 2'd0);
            end
            #1;
            exp_d = q5_0.pop_front();
            n_cmp++;
            if (if5.output_Data !== exp_d) begin
                n_bad++; $display("FAIL wrap_data[%0d]: got %h want %h", i, if5.output_Data, exp_d);
            end
            if (i < 9) begin
                q5_0.push_back(32'h500 + n);
                n++;
            end
            tick();
        end
        drive5(1'b0, 2'd0, '0, 1'b0, 2'd0);
        n_cmp++;
        if (if5.buf_empty[0] !== 1'b1 || if5.num_Flits[0] !== 3'd0 || if5.underflow_o !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_end: got empty %b count %0d unf %b want 1 0 0",
                     if5.buf_empty[0], if5.num_Flits[0], if5.underflow_o);
        end
    endtask

    task automatic test_empty_rw();
        drive5(1'b1, 2'd0, 32'h55, 1'b1, 2'd0);
        q5_0.push_back(32'h55);
        tick();
        drive5(1'b0, 2'd0, '0, 1'b0, 2'd0);
        n_cmp++;
        if (if5.underflow_o !== 1'b1 || if5.num_Flits[0] !== 3'd1) begin
            n_bad++;
            $display("FAIL empty_rw_state: got unf %b count %0d want 1 1",
                     if5.underflow_o, if5.num_Flits[0]);
        end
        drive5(1'b0, 2'd0, '0, 1'b1, 2'd0);
        #1;
        exp_d = q5_0.pop_front();
        n_cmp++;
        if (if5.output_Data !== exp_d) begin
            n_bad++; $display("FAIL empty_rw_head: got %h want %h", if5.output_Data, exp_d);
        end
        tick();
        drive5(1'b0, 2'd0, '0, 1'b0, 2'd0);
        n_cmp++;
        if (if5.buf_empty[0] !== 1'b1 || if5.underflow_o !== 1'b0) begin
            n_bad++;
            $display("FAIL empty_rw_after: got empty %b unf %b want 1 0",
                     if5.buf_empty[0], if5.underflow_o);
        end
    endtask

    task automatic test_out_of_range();
        drive5(1'b1, 2'd3, 32'h77, 1'b0, 2'd0);
        tick();
        drive5(1'b0, 2'd0, '0, 1'b1, 2'd3);
        n_cmp++;
        if (if5.overflow_o !== 1'b1 || if5.num_Flits !== 9'h000) begin
            n_bad++;
            $display("FAIL oor_write: got ovf %b counts %h want 1 000",
                     if5.overflow_o, if5.num_Flits);
        end
        tick();
        drive5(1'b0, 2'd0, '0, 1'b0, 2'd0);
        n_cmp++;
        if (if5.underflow_o !== 1'b1 || if5.overflow_o !== 1'b0) begin
            n_bad++;
            $display("FAIL oor_read: got unf %b ovf %b want 1 0",
                     if5.underflow_o, if5.overflow_o);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            drive5(1'b1, 2'd1, 32'h800 + i, 1'b0, 2'd1);
            q5_1.push_back(32'h800 + i);
            tick();
        end
        drive5(1'b1, 2'd2, 32'h900, 1'b1, 2'd1);
        q5_2.push_back(32'h900);
        #1;
        exp_d = q5_1.pop_front();
        n_cmp++;
        if (if5.output_Data !== exp_d) begin
            n_bad++; $display("FAIL b2b_pop: got %h want %h", if5.output_Data, exp_d);
        end
        tick();
        drive5(1'b0, 2'd0, '0, 1'b0, 2'd0);
        n_cmp++;
        if (if5.num_Flits[1] !== 3'd1 || if5.num_Flits[2] !== 3'd1 ||
            if5.overflow_o !== 1'b0 || if5.underflow_o !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_counts: got %0d %0d ovf %b unf %b want 1 1 0 0",
                     if5.num_Flits[1], if5.num_Flits[2], if5.overflow_o, if5.underflow_o);
        end
        drive5(1'b0, 2'd0, '0, 1'b1, 2'd2);
        #1;
        exp_d = q5_2.pop_front();
        n_cmp++;
        if (if5.output_Data !== exp_d) begin
            n_bad++; $display("FAIL b2b_vc2: got %h want %h", if5.output_Data, exp_d);
        end
        tick();
        drive5(1'b0, 2'd0, '0, 1'b1, 2'd1);
        #1;
        exp_d = q5_1.pop_front();
        n_cmp++;
        if (if5.output_Data !== exp_d) begin
            n_bad++; $display("FAIL b2b_vc1: got %h want %h", if5.output_Data, exp_d);
        end
        tick();
        drive5(1'b0, 2'd0, '0, 1'b0, 2'd0);
        n_cmp++;
        if (if5.buf_empty !== 3'b111) begin
            n_bad++; $display("FAIL b2b_empty: got %b want 111", if5.buf_empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill_vc1();
        test_overflow();
        test_full_rw();
        test_drain_reset();
        test_wrap();
        test_empty_rw();
        test_out_of_range();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1);
    end

endmodule
